// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and helpers
// for the pipelined add/subtract unit.
package addsub_pkg;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
  } flags_t;

  function automatic int slice_w(
    input int width,
    input int stages
  );
    return width / stages;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: one carry slice of the adder
// with its own valid/ready pipeline register.
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] res_i,
  input  logic             c_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] res_o,
  output logic             c_o
);

  localparam int SW = slice_w(WIDTH, STAGES);
  localparam int LO = IDX * SW;

  logic [SW:0]      add;
  logic [WIDTH-1:0] res_d;

  logic             valid_q;
  logic             c_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;

  always_comb begin
    add = {1'b0, a_i[LO +: SW]}
        + {1'b0, b_i[LO +: SW]}
        + {{SW{1'b0}}, c_i};
    res_d = res_i;
    res_d[LO +: SW] = add[SW-1:0];
  end

  // Advance when empty or when the next stage drains us.
  assign ready_o = ~valid_q | ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        c_q   <= add[SW];
        a_q   <= a_i;
        b_q   <= b_i;
        res_q <= res_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign c_o     = c_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign res_o   = res_q;

endmodule

// File: rtl/pipelined_addsub_p.sv
// pipelined_addsub_p: STAGES-deep add/subtract
// with carry, overflow and zero flags.
module pipelined_addsub_p
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             C_out,
  output logic             ovf,
  output logic             zero
);

  logic             v_s   [STAGES+1];
  logic             r_s   [STAGES+1];
  logic             c_s   [STAGES+1];
  logic [WIDTH-1:0] a_s   [STAGES+1];
  logic [WIDTH-1:0] b_s   [STAGES+1];
  logic [WIDTH-1:0] res_s [STAGES+1];

  flags_t fl;
  logic   unused_ok;

  assign v_s[0]      = in_valid;
  assign in_ready    = r_s[0];
  assign r_s[STAGES] = out_ready;
  assign c_s[0]      = C_in;
  assign a_s[0]      = A;
  assign b_s[0]      = sub ? ~B : B;
  assign res_s[0]    = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    addsub_slice #(
      .WIDTH (WIDTH),
      .STAGES(STAGES),
      .IDX   (k)
    ) u_slice (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid_i(v_s[k]),
      .ready_o(r_s[k]),
      .a_i    (a_s[k]),
      .b_i    (b_s[k]),
      .res_i  (res_s[k]),
      .c_i    (c_s[k]),
      .valid_o(v_s[k+1]),
      .ready_i(r_s[k+1]),
      .a_o    (a_s[k+1]),
      .b_o    (b_s[k+1]),
      .res_o  (res_s[k+1]),
      .c_o    (c_s[k+1])
    );
  end

  // Only the sign bits of the delayed operands matter at the end.
  assign unused_ok = ^{a_s[STAGES][WIDTH-2:0],
                       b_s[STAGES][WIDTH-2:0]};

  assign fl.c = c_s[STAGES];
  assign fl.v = (a_s[STAGES][WIDTH-1] == b_s[STAGES][WIDTH-1])
             && (res_s[STAGES][WIDTH-1] != a_s[STAGES][WIDTH-1]);
  assign fl.z = v_s[STAGES] & ~|res_s[STAGES];

  assign out_valid = v_s[STAGES];
  assign sum       = res_s[STAGES];
  assign C_out     = fl.c;
  assign ovf       = fl.v;
  assign zero      = fl.z;

endmodule

// File: tb/tb_pipelined_addsub_p.sv
// tb_pipelined_addsub_p: scoreboard bench for
// 64/4, 32/1 and 64/8 configurations.
module tb_pipelined_addsub_p;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        C_in = 1'b0;
  logic        sub = 1'b0;
  logic [63:0] A = '0;
  logic [63:0] B = '0;

  always #5 clk = ~clk;

  logic        rdy4, vf4, co4, ov4, z4;
  logic [63:0] s4;
  logic        rdy1, vf1, co1, ov1, z1;
  logic [31:0] s1;
  logic        rdy8, vf8, co8, ov8, z8;
  logic [63:0] s8;

  pipelined_addsub_p #(.WIDTH(64), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy4),
    .A(A), .B(B), .C_in(C_in), .sub(sub),
    .out_valid(vf4), .out_ready(out_ready),
    .sum(s4), .C_out(co4), .ovf(ov4), .zero(z4)
  );

  pipelined_addsub_p #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy1),
    .A(A[31:0]), .B(B[31:0]), .C_in(C_in), .sub(sub),
    .out_valid(vf1), .out_ready(out_ready),
    .sum(s1), .C_out(co1), .ovf(ov1), .zero(z1)
  );

  pipelined_addsub_p #(.WIDTH(64), .STAGES(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy8),
    .A(A), .B(B), .C_in(C_in), .sub(sub),
    .out_valid(vf8), .out_ready(out_ready),
    .sum(s8), .C_out(co8), .ovf(ov8), .zero(z8)
  );

  typedef struct packed {
    logic        c;
    logic        v;
    logic        z;
    logic [63:0] s;
  } res_t;

  res_t q4[$];
  res_t q1[$];
  res_t q8[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   n_acc1 = 0;
  int   n_acc8 = 0;

  function automatic res_t model(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        ci,
    input logic        sb,
    input int          w
  );
    logic [63:0] m, aa, be;
    logic [64:0] full;
    res_t r;
    m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = a & m;
    be   = (sb ? ~b : b) & m;
    full = {1'b0, aa} + {1'b0, be} + {64'd0, ci};
    r.s  = full[63:0] & m;
    r.c  = full[w];
    r.v  = (aa[w-1] == be[w-1]) && (r.s[w-1] != aa[w-1]);
    r.z  = (r.s == 64'd0);
    return r;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h0000_0000_7FFF_FFFF;
      5: return 64'h0000_0000_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic chk(
    input string       tag,
    input logic [66:0] obs,
    input logic [66:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(
    input string       tag,
    input logic [66:0] obs,
    input int          qsz,
    input res_t        exp
  );
    n_assert++;
    assert (qsz > 0 && obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (queued %0d)",
             tag, obs, exp, qsz);
    end
  endtask

  always @(negedge clk) begin
    res_t e;
    int   sz;
    if (!rst_n) begin
      q4.delete();
      q1.delete();
      q8.delete();
    end else begin
      if (vf4 && out_ready) begin
        sz = q4.size();
        e  = '0;
        if (sz > 0) e = q4.pop_front();
        chk_out("out_s4", {co4, ov4, z4, s4}, sz, e);
      end
      if (vf1 && out_ready) begin
        sz = q1.size();
        e  = '0;
        if (sz > 0) e = q1.pop_front();
        chk_out("out_s1", {co1, ov1, z1, 32'd0, s1}, sz, e);
      end
      if (vf8 && out_ready) begin
        sz = q8.size();
        e  = '0;
        if (sz > 0) e = q8.pop_front();
        chk_out("out_s8", {co8, ov8, z8, s8}, sz, e);
      end
      if (in_valid && rdy4) q4.push_back(model(A, B, C_in, sub, 64));
      if (in_valid && rdy1) begin
        q1.push_back(model(A, B, C_in, sub, 32));
        n_acc1++;
      end
      if (in_valid && rdy8) begin
        q8.push_back(model(A, B, C_in, sub, 64));
        n_acc8++;
      end
    end
  end

  task automatic one_op(
    input string       tag,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        ci,
    input logic        sb,
    input logic [66:0] exp
  );
    int lat;
    A = a; B = b; C_in = ci; sub = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!vf4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 67'(lat), 67'(4));
    chk(tag, {co4, ov4, z4, s4}, exp);
    @(posedge clk); #1;
  endtask

  task automatic step(input logic [63:0] a, input logic [63:0] b,
                      input logic ci, input logic sb, output logic acc);
    A = a; B = b; C_in = ci; sub = sb; in_valid = 1'b1;
    @(negedge clk);
    acc = rdy4;
    @(posedge clk); #1;
  endtask

  logic [63:0] ba [10];
  logic [63:0] bb [10];
  logic        bc [10];
  logic        bs [10];

  initial begin
    int   idx, cnt;
    logic acc;
    res_t e;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ctl", 67'({rdy4, vf4, co4, ov4, z4}), 67'(5'b10000));
    chk("rst_sum", 67'(s4), 67'(0));
    @(posedge clk); #1;

    one_op("add_carry", '1, 64'd1, 1'b0, 1'b0,
           {1'b1, 1'b0, 1'b1, 64'h0});
    one_op("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
           {1'b0, 1'b1, 1'b0, 64'h8000_0000_0000_0000});
    one_op("subtract", 64'd5, 64'd7, 1'b1, 1'b1,
           {1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});

    for (int i = 0; i < 10; i++) begin
      ba[i] = {$urandom, $urandom};
      bb[i] = {$urandom, $urandom};
      bc[i] = 1'($urandom_range(0, 1));
      bs[i] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      step(ba[idx], bb[idx], bc[idx], bs[idx], acc);
      if (acc) idx++;
    end
    chk("bp_accepted", 67'(idx), 67'(4));
    chk("bp_in_ready", 67'(rdy4), 67'(0));
    e = model(ba[0], bb[0], bc[0], bs[0], 64);
    chk("bp_hold", {co4, ov4, z4, s4}, e);
    out_ready = 1'b1;
    cnt = 0;
    while (idx < 10 && cnt < 100) begin
      step(ba[idx], bb[idx], bc[idx], bs[idx], acc);
      if (acc) idx++;
      cnt++;
    end
    in_valid = 1'b0;
    chk("bp_all_in", 67'(idx), 67'(10));
    repeat (12) @(posedge clk);
    #1;

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(64'd100 + 64'(i), 64'd3, 1'b0, 1'b0, acc);
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", 67'(vf4), 67'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 67'(vf4), 67'(0));
    chk("rst_mid_sum", 67'(s4), 67'(0));
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (vf4 || vf1 || vf8) cnt++;
    end
    chk("rst_no_emit", 67'(cnt), 67'(0));
    @(posedge clk); #1;

    n_acc1 = 0;
    n_acc8 = 0;
    cnt = 0;
    while ((n_acc1 < 1000 || n_acc8 < 1000) && cnt < 20000) begin
      A = pick();
      B = pick();
      C_in = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cnt++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("sweep_s1_ops", 67'(n_acc1 >= 1000), 67'(1));
    chk("sweep_s8_ops", 67'(n_acc8 >= 1000), 67'(1));

    cnt = 0;
    while ((q4.size() + q1.size() + q8.size()) != 0 && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("drain_s4", 67'(q4.size()), 67'(0));
    chk("drain_s1", 67'(q1.size()), 67'(0));
    chk("drain_s8", 67'(q8.size()), 67'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
